decode_stage: RTL and testbench



---
 rtl/decode_stage.sv | 275 +++++++++++++++++++++++++++
 tb/tb_decode_stage.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// RV32I/RV32IM decode stage with a registered 2-entry skid buffer.
// Decode is combinational on the incoming word; results live in head/skid entries.
module decode_stage #(
  parameter int unsigned XLEN          = 32,
  parameter bit          ENABLE_M      = 1'b0,
  parameter int unsigned INVALID_CNT_W = 8
) (
  input  logic                     Clock,
  input  logic                     Reset_n,
  input  logic                     Flush,
  input  logic                     InValid,
  output logic                     InReady,
  input  logic [31:0]              Instruction,
  input  logic [XLEN-1:0]          InPC,
  output logic                     OutValid,
  input  logic                     OutReady,
  output logic [XLEN-1:0]          OutPC,
  output logic [4:0]               RD,
  output logic [4:0]               RS1,
  output logic [4:0]               RS2,
  output logic [XLEN-1:0]          DecodedImediate,
  output logic [2:0]               LHSsource,
  output logic [1:0]               RHSsource,
  output logic [3:0]               ALUOperation,
  output logic                     WritesRegisterFile,
  output logic                     IsBranchInstruction,
  output logic                     IsJumpInstruction,
  output logic                     JumpMode,
  output logic                     IsMemoryRead,
  output logic                     IsMemoryWrite,
  output logic                     MemoryAccessSignExtend,
  output logic [2:0]               BranchCondition,
  output logic [1:0]               MemoryAccessWidth,
  output logic                     IsMulDiv,
  output logic                     IsSystem,
  output logic                     IsFence,
  output logic                     InvalidInstructionSignal,
  output logic [INVALID_CNT_W-1:0] InvalidCount
);

  typedef enum logic [6:0] {
    OPC_LOAD     = 7'b0000011,
    OPC_MISC_MEM = 7'b0001111,
    OPC_OP_IMM   = 7'b0010011,
    OPC_AUIPC    = 7'b0010111,
    OPC_STORE    = 7'b0100011,
    OPC_OP       = 7'b0110011,
    OPC_LUI      = 7'b0110111,
    OPC_BRANCH   = 7'b1100011,
    OPC_JALR     = 7'b1100111,
    OPC_JAL      = 7'b1101111,
    OPC_SYSTEM   = 7'b1110011
  } opcode_e;

  typedef enum logic [2:0] {LHS_REG = 3'd0, LHS_IMM = 3'd1, LHS_PC = 3'd4} lhs_e;
  typedef enum logic [1:0] {RHS_REG = 2'd0, RHS_IMM = 2'd1, RHS_FOUR = 2'd3} rhs_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
    logic [2:0]      lhs;
    logic [1:0]      rhs;
    logic [3:0]      alu;
    logic            wr;
    logic            br;
    logic            jmp;
    logic            jmode;
    logic            mrd;
    logic            mwr;
    logic            msext;
    logic [2:0]      bcond;
    logic [1:0]      width;
    logic            muldiv;
    logic            sys;
    logic            fence;
    logic            invalid;
  } dec_t;

  function automatic logic [XLEN-1:0] sx(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  opcode_e    opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opc   = opcode_e'(Instruction[6:0]);
  assign f3    = Instruction[14:12];
  assign f7    = Instruction[31:25];
  assign imm_i = {{20{Instruction[31]}}, Instruction[31:20]};
  assign imm_s = {{20{Instruction[31]}}, Instruction[31:25], Instruction[11:7]};
  assign imm_b = {{19{Instruction[31]}}, Instruction[31], Instruction[7],
                  Instruction[30:25], Instruction[11:8], 1'b0};
  assign imm_u = {Instruction[31:12], 12'b0};
  assign imm_j = {{11{Instruction[31]}}, Instruction[31], Instruction[19:12],
                  Instruction[20], Instruction[30:21], 1'b0};

  dec_t dec;
  logic inv;

  // Combinational decode of the offered instruction word.
  always_comb begin
    dec     = '0;
    inv     = 1'b0;
    dec.pc  = InPC;
    dec.rd  = Instruction[11:7];
    dec.rs1 = Instruction[19:15];
    dec.rs2 = Instruction[24:20];
    case (opc)
      OPC_LUI: begin
        dec.imm = sx(imm_u); dec.lhs = LHS_IMM; dec.rhs = RHS_IMM;
        dec.alu = 4'b0111;   dec.wr = 1'b1;
      end
      OPC_AUIPC: begin
        dec.imm = sx(imm_u); dec.lhs = LHS_PC; dec.rhs = RHS_IMM; dec.wr = 1'b1;
      end
      OPC_OP_IMM: begin
        dec.imm = sx(imm_i); dec.lhs = LHS_REG; dec.rhs = RHS_IMM;
        dec.alu = {1'b0, f3}; dec.wr = 1'b1;
        if (f3 == 3'b001) inv = (f7 != 7'b0000000);
        if (f3 == 3'b101) begin
          inv     = (f7 != 7'b0000000) && (f7 != 7'b0100000);
          dec.alu = {Instruction[30], f3};
        end
      end
      OPC_OP: begin
        dec.lhs = LHS_REG; dec.rhs = RHS_REG;
        dec.alu = {Instruction[30], f3}; dec.wr = 1'b1;
        case (f7)
          7'b0000000: ;
          7'b0100000: inv = !((f3 == 3'b000) || (f3 == 3'b101));
          7'b0000001: begin
            if (ENABLE_M) begin
              dec.muldiv = 1'b1;
              dec.alu    = {1'b0, f3};
            end else begin
              inv = 1'b1;
            end
          end
          default: inv = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        dec.imm = sx(imm_i); dec.lhs = LHS_REG; dec.rhs = RHS_IMM;
        dec.mrd = 1'b1; dec.wr = 1'b1;
        dec.width = f3[1:0]; dec.msext = !f3[2];
        inv = (f3 == 3'b011) || (f3[2:1] == 2'b11);
      end
      OPC_STORE: begin
        dec.imm = sx(imm_s); dec.lhs = LHS_REG; dec.rhs = RHS_IMM;
        dec.mwr = 1'b1; dec.width = f3[1:0];
        inv = (f3 > 3'b010);
      end
      OPC_BRANCH: begin
        dec.imm = sx(imm_b); dec.br = 1'b1;
        case (f3)
          3'b000:  dec.bcond = 3'd0;
          3'b001:  dec.bcond = 3'd1;
          3'b100:  dec.bcond = 3'd3;
          3'b101:  dec.bcond = 3'd5;
          3'b110:  dec.bcond = 3'd2;
          3'b111:  dec.bcond = 3'd4;
          default: inv = 1'b1;
        endcase
      end
      OPC_JAL: begin
        dec.imm = sx(imm_j); dec.lhs = LHS_PC; dec.rhs = RHS_FOUR;
        dec.jmp = 1'b1; dec.wr = 1'b1;
      end
      OPC_JALR: begin
        dec.imm = sx(imm_i); dec.lhs = LHS_PC; dec.rhs = RHS_FOUR;
        dec.jmp = 1'b1; dec.jmode = 1'b1; dec.wr = 1'b1;
        inv = (f3 != 3'b000);
      end
      OPC_MISC_MEM: dec.fence = 1'b1;
      OPC_SYSTEM: begin
        if ((Instruction == 32'h0000_0073) || (Instruction == 32'h0010_0073)) dec.sys = 1'b1;
        else inv = 1'b1;
      end
      default: inv = 1'b1;
    endcase
    // Invalid words still flow through, but must never cause side effects.
    if (inv) begin
      dec.wr = 1'b0; dec.br = 1'b0; dec.jmp = 1'b0; dec.jmode = 1'b0;
      dec.mrd = 1'b0; dec.mwr = 1'b0; dec.msext = 1'b0; dec.width = 2'd0;
      dec.muldiv = 1'b0; dec.sys = 1'b0; dec.fence = 1'b0;
    end
    dec.invalid = inv;
  end

  dec_t                     head_q, head_d, skid_q, skid_d;
  logic                     head_v_q, head_v_d, skid_v_q, skid_v_d;
  logic [INVALID_CNT_W-1:0] cnt_q, cnt_d;
  logic                     in_fire, out_fire;

  assign in_fire  = InValid && !skid_v_q;
  assign out_fire = head_v_q && OutReady;

  // Skid-buffer next state; the skid entry is only filled while the head is stalled.
  always_comb begin
    head_d   = head_q;
    skid_d   = skid_q;
    head_v_d = head_v_q;
    skid_v_d = skid_v_q;
    cnt_d    = cnt_q;
    if (Flush) begin
      head_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else begin
      if (in_fire && dec.invalid && (cnt_q != '1)) cnt_d = cnt_q + INVALID_CNT_W'(1);
      if (skid_v_q) begin
        if (out_fire) begin
          head_d   = skid_q;
          skid_v_d = 1'b0;
        end
      end else if (head_v_q && !out_fire) begin
        if (in_fire) begin
          skid_d   = dec;
          skid_v_d = 1'b1;
        end
      end else begin
        // Head empty or draining: a new decode lands directly in the head.
        head_v_d = in_fire;
        if (in_fire) head_d = dec;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      head_q   <= '0;
      skid_q   <= '0;
      head_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      head_q   <= head_d;
      skid_q   <= skid_d;
      head_v_q <= head_v_d;
      skid_v_q <= skid_v_d;
      cnt_q    <= cnt_d;
    end
  end

  assign InReady                  = !skid_v_q;
  assign OutValid                 = head_v_q;
  assign OutPC                    = head_q.pc;
  assign RD                       = head_q.rd;
  assign RS1                      = head_q.rs1;
  assign RS2                      = head_q.rs2;
  assign DecodedImediate          = head_q.imm;
  assign LHSsource                = head_q.lhs;
  assign RHSsource                = head_q.rhs;
  assign ALUOperation             = head_q.alu;
  assign WritesRegisterFile       = head_q.wr;
  assign IsBranchInstruction      = head_q.br;
  assign IsJumpInstruction        = head_q.jmp;
  assign JumpMode                 = head_q.jmode;
  assign IsMemoryRead             = head_q.mrd;
  assign IsMemoryWrite            = head_q.mwr;
  assign MemoryAccessSignExtend   = head_q.msext;
  assign BranchCondition          = head_q.bcond;
  assign MemoryAccessWidth        = head_q.width;
  assign IsMulDiv                 = head_q.muldiv;
  assign IsSystem                 = head_q.sys;
  assign IsFence                  = head_q.fence;
  assign InvalidInstructionSignal = head_q.invalid;
  assign InvalidCount             = cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: ENABLE_M=0 main instance, ENABLE_M=1/2-bit counter side instance.
module tb_decode_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [2:0]  lhs;
    logic [1:0]  rhs;
    logic [3:0]  alu;
    logic        wr, br, jmp, jmode, mrd, mwr, sext;
    logic [2:0]  bcond;
    logic [1:0]  width;
    logic        muldiv, sys, fence, inv;
  } exp_t;

  logic Clock = 1'b0, Reset_n = 1'b0, Flush = 1'b0;
  always #5 Clock = ~Clock;

  // main instance signals
  logic        InValid = 1'b0, InReady, OutValid, OutReady = 1'b1;
  logic [31:0] Instruction = '0, InPC = '0, OutPC, DecodedImediate;
  logic [4:0]  RD, RS1, RS2;
  logic [2:0]  LHSsource, BranchCondition;
  logic [1:0]  RHSsource, MemoryAccessWidth;
  logic [3:0]  ALUOperation;
  logic        WritesRegisterFile, IsBranchInstruction, IsJumpInstruction, JumpMode;
  logic        IsMemoryRead, IsMemoryWrite, MemoryAccessSignExtend;
  logic        IsMulDiv, IsSystem, IsFence, InvalidInstructionSignal;
  logic [7:0]  InvalidCount;

  // side instance signals
  logic        InValid_b = 1'b0, InReady_b, OutValid_b, OutReady_b = 1'b1;
  logic [31:0] Instruction_b = '0, OutPC_b, Imm_b;
  logic [4:0]  RD_b, RS1_b, RS2_b;
  logic [2:0]  LHS_b, BCond_b;
  logic [1:0]  RHS_b, Width_b;
  logic [3:0]  ALU_b;
  logic        Wr_b, Br_b, Jmp_b, JMode_b, MRd_b, MWr_b, SExt_b;
  logic        MulDiv_b, Sys_b, Fence_b, Inv_b;
  logic [1:0]  InvalidCount_b;

  decode_stage #(.XLEN(32), .ENABLE_M(1'b0), .INVALID_CNT_W(8)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .Flush(Flush),
    .InValid(InValid), .InReady(InReady), .Instruction(Instruction), .InPC(InPC),
    .OutValid(OutValid), .OutReady(OutReady), .OutPC(OutPC),
    .RD(RD), .RS1(RS1), .RS2(RS2), .DecodedImediate(DecodedImediate),
    .LHSsource(LHSsource), .RHSsource(RHSsource), .ALUOperation(ALUOperation),
    .WritesRegisterFile(WritesRegisterFile), .IsBranchInstruction(IsBranchInstruction),
    .IsJumpInstruction(IsJumpInstruction), .JumpMode(JumpMode),
    .IsMemoryRead(IsMemoryRead), .IsMemoryWrite(IsMemoryWrite),
    .MemoryAccessSignExtend(MemoryAccessSignExtend), .BranchCondition(BranchCondition),
    .MemoryAccessWidth(MemoryAccessWidth), .IsMulDiv(IsMulDiv), .IsSystem(IsSystem),
    .IsFence(IsFence), .InvalidInstructionSignal(InvalidInstructionSignal),
    .InvalidCount(InvalidCount)
  );

  decode_stage #(.XLEN(32), .ENABLE_M(1'b1), .INVALID_CNT_W(2)) dut_b (
    .Clock(Clock), .Reset_n(Reset_n), .Flush(Flush),
    .InValid(InValid_b), .InReady(InReady_b), .Instruction(Instruction_b), .InPC(InPC),
    .OutValid(OutValid_b), .OutReady(OutReady_b), .OutPC(OutPC_b),
    .RD(RD_b), .RS1(RS1_b), .RS2(RS2_b), .DecodedImediate(Imm_b),
    .LHSsource(LHS_b), .RHSsource(RHS_b), .ALUOperation(ALU_b),
    .WritesRegisterFile(Wr_b), .IsBranchInstruction(Br_b),
    .IsJumpInstruction(Jmp_b), .JumpMode(JMode_b),
    .IsMemoryRead(MRd_b), .IsMemoryWrite(MWr_b),
    .MemoryAccessSignExtend(SExt_b), .BranchCondition(BCond_b),
    .MemoryAccessWidth(Width_b), .IsMulDiv(MulDiv_b), .IsSystem(Sys_b),
    .IsFence(Fence_b), .InvalidInstructionSignal(Inv_b),
    .InvalidCount(InvalidCount_b)
  );

  int   vectors = 0, miscompares = 0, n_out = 0;
  int   inv_exp = 0;
  exp_t sbq[$];
  logic [31:0] vins[$];
  exp_t        vexp[$];
  logic [31:0] pc_n = 32'h100;

  // Output monitor: every transfer out of the main instance is checked against the scoreboard.
  always @(negedge Clock) begin
    exp_t act, e;
    if (Reset_n && !Flush && OutValid && OutReady) begin
      act = '{OutPC, RD, RS1, RS2, DecodedImediate, LHSsource, RHSsource, ALUOperation,
              WritesRegisterFile, IsBranchInstruction, IsJumpInstruction, JumpMode,
              IsMemoryRead, IsMemoryWrite, MemoryAccessSignExtend, BranchCondition,
              MemoryAccessWidth, IsMulDiv, IsSystem, IsFence, InvalidInstructionSignal};
      vectors++;
      n_out++;
      if (sbq.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_output got=%h required=none", act);
      end else begin
        e = sbq.pop_front();
        if (act !== e) begin
          miscompares++;
          $display("FAIL scoreboard got=%h required=%h", act, e);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time_limit reached");
    $fatal(1);
  end

  function automatic exp_t mk(input logic [31:0] ins, input logic [31:0] pc);
    exp_t e;
    e     = '0;
    e.pc  = pc;
    e.rd  = ins[11:7];
    e.rs1 = ins[19:15];
    e.rs2 = ins[24:20];
    return e;
  endfunction

  task automatic step();
    @(posedge Clock); #1;
  endtask

  task automatic send(input logic [31:0] ins, input exp_t e);
    int n = 0;
    InValid = 1'b1; Instruction = ins; InPC = e.pc;
    while (!InReady && n < 50) begin step(); n++; end
    vectors++;
    if (!InReady) begin
      miscompares++;
      $display("FAIL send_timeout inready=%b required=1", InReady);
    end else begin
      sbq.push_back(e);
      if (e.inv) inv_exp++;
    end
    step();
    InValid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sbq.size() != 0 && n < 100) begin step(); n++; end
    vectors++;
    if (sbq.size() != 0) begin
      miscompares++;
      $display("FAIL drain_timeout pending=%0d required=0", sbq.size());
    end
  endtask

  task automatic add(input logic [31:0] ins, input exp_t e);
    vins.push_back(ins);
    vexp.push_back(e);
    pc_n += 32'd4;
  endtask

  task automatic build_vectors();
    exp_t e;
    e = mk(32'h00832283, pc_n); e.imm = 8; e.rhs = 1; e.wr = 1; e.mrd = 1; e.width = 2; e.sext = 1; add(32'h00832283, e);
    e = mk(32'h40315093, pc_n); e.imm = 32'h403; e.rhs = 1; e.alu = 4'b1101; e.wr = 1; add(32'h40315093, e);
    e = mk(32'h123450B7, pc_n); e.imm = 32'h12345000; e.lhs = 1; e.rhs = 1; e.alu = 4'b0111; e.wr = 1; add(32'h123450B7, e);
    e = mk(32'hFFFFF117, pc_n); e.imm = 32'hFFFFF000; e.lhs = 4; e.rhs = 1; e.wr = 1; add(32'hFFFFF117, e);
    e = mk(32'h00112223, pc_n); e.imm = 4; e.rhs = 1; e.mwr = 1; e.width = 2; add(32'h00112223, e);
    e = mk(32'hFE209EE3, pc_n); e.imm = 32'hFFFFFFFC; e.br = 1; e.bcond = 1; add(32'hFE209EE3, e);
    e = mk(32'hFE20EEE3, pc_n); e.imm = 32'hFFFFFFFC; e.br = 1; e.bcond = 2; add(32'hFE20EEE3, e);
    e = mk(32'h008000EF, pc_n); e.imm = 8; e.lhs = 4; e.rhs = 3; e.jmp = 1; e.wr = 1; add(32'h008000EF, e);
    e = mk(32'h000080E7, pc_n); e.lhs = 4; e.rhs = 3; e.jmp = 1; e.jmode = 1; e.wr = 1; add(32'h000080E7, e);
    e = mk(32'h00000073, pc_n); e.sys = 1; add(32'h00000073, e);
    e = mk(32'h00100073, pc_n); e.sys = 1; add(32'h00100073, e);
    e = mk(32'h0FF0000F, pc_n); e.fence = 1; add(32'h0FF0000F, e);
    e = mk(32'h40208033, pc_n); e.alu = 4'b1000; e.wr = 1; add(32'h40208033, e);
    e = mk(32'h0000C283, pc_n); e.rhs = 1; e.mrd = 1; e.wr = 1; add(32'h0000C283, e);
  endtask

  function automatic exp_t addi_exp(input logic [31:0] pc);
    exp_t e;
    e = mk(32'hFFF10093, pc); e.imm = 32'hFFFFFFFF; e.rhs = 1; e.wr = 1;
    return e;
  endfunction

  task automatic test_reset();
    Reset_n = 1'b0; OutReady = 1'b1;
    step(); step();
    vectors++;
    if ({OutValid, InReady} !== 2'b01) begin
      miscompares++; $display("FAIL reset_handshake got=%b required=01", {OutValid, InReady});
    end
    vectors++;
    if (InvalidCount !== 8'd0) begin
      miscompares++; $display("FAIL reset_count got=%0d required=0", InvalidCount);
    end
    vectors++;
    if ({RD, DecodedImediate, LHSsource, ALUOperation, WritesRegisterFile, InvalidInstructionSignal} !== '0) begin
      miscompares++; $display("FAIL reset_outputs rd=%0d imm=%h alu=%b got nonzero required=0", RD, DecodedImediate, ALUOperation);
    end
    Reset_n = 1'b1;
    step();
  endtask

  task automatic test_latency();
    OutReady = 1'b1;
    send(32'hFFF10093, addi_exp(32'h80));
    vectors++;
    if (OutValid !== 1'b1) begin
      miscompares++; $display("FAIL latency outvalid=%b required=1", OutValid);
    end
    wait_drain();
  endtask

  task automatic test_decode_mix();
    OutReady = 1'b1;
    foreach (vins[i]) send(vins[i], vexp[i]);
    wait_drain();
  endtask

  task automatic test_invalid();
    exp_t e;
    OutReady = 1'b1;
    e = mk(32'h02208033, 32'h200); e.inv = 1; send(32'h02208033, e);
    e = mk(32'h00000000, 32'h204); e.inv = 1; send(32'h00000000, e);
    e = mk(32'h40111093, 32'h208); e.inv = 1; e.imm = 32'h401; e.rhs = 1; e.alu = 4'b0001; send(32'h40111093, e);
    e = mk(32'h40209033, 32'h20C); e.inv = 1; e.alu = 4'b1001; send(32'h40209033, e);
    e = mk(32'h0000B283, 32'h210); e.inv = 1; e.rhs = 1; send(32'h0000B283, e);
    e = mk(32'h00200073, 32'h214); e.inv = 1; send(32'h00200073, e);
    e = mk(32'hFFFFFFFF, 32'h218); e.inv = 1; e.imm = 32'h0; send(32'hFFFFFFFF, e);
    wait_drain();
    vectors++;
    if (InvalidCount !== 8'(inv_exp)) begin
      miscompares++; $display("FAIL invalid_count got=%0d required=%0d", InvalidCount, inv_exp);
    end
  endtask

  task automatic test_muldiv_enabled();
    InValid_b = 1'b1; Instruction_b = 32'h02208033;
    step();
    InValid_b = 1'b0;
    vectors++;
    if ({OutValid_b, MulDiv_b, ALU_b, Inv_b, Wr_b} !== {1'b1, 1'b1, 4'b0000, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL muldiv_m1 got v=%b md=%b alu=%b inv=%b wr=%b required v=1 md=1 alu=0000 inv=0 wr=1",
               OutValid_b, MulDiv_b, ALU_b, Inv_b, Wr_b);
    end
  endtask

  task automatic test_back_to_back();
    int c0, o0;
    OutReady = 1'b1;
    o0 = n_out;
    c0 = 0;
    for (int i = 0; i < 4; i++) begin
      send(vins[i], vexp[i]);
      c0++;
      vectors++;
      if (InReady !== 1'b1) begin
        miscompares++; $display("FAIL b2b_inready idx=%0d got=%b required=1", i, InReady);
      end
    end
    step();
    vectors++;
    if (n_out - o0 !== 4) begin
      miscompares++; $display("FAIL b2b_outputs got=%0d required=4", n_out - o0);
    end
    wait_drain();
  endtask

  task automatic test_stall_order();
    exp_t ec;
    int o0, n;
    OutReady = 1'b0;
    send(32'hFFF10093, addi_exp(32'h300));
    send(vins[0], vexp[0]);
    vectors++;
    if ({OutValid, InReady} !== 2'b10) begin
      miscompares++; $display("FAIL stall_full got v/r=%b required=10", {OutValid, InReady});
    end
    ec = vexp[1]; ec.pc = 32'h308;
    InValid = 1'b1; Instruction = vins[1]; InPC = ec.pc;
    o0 = n_out;
    step(); step();
    vectors++;
    if ({InReady, OutPC} !== {1'b0, 32'h300}) begin
      miscompares++; $display("FAIL stall_hold got r=%b pc=%h required r=0 pc=00000300", InReady, OutPC);
    end
    vectors++;
    if (n_out !== o0) begin
      miscompares++; $display("FAIL stall_no_output got=%0d required=%0d", n_out, o0);
    end
    sbq.push_back(ec);
    OutReady = 1'b1;
    step();
    vectors++;
    if (InReady !== 1'b1) begin
      miscompares++; $display("FAIL inready_recover got=%b required=1", InReady);
    end
    step();
    InValid = 1'b0;
    n = 0;
    wait_drain();
  endtask

  task automatic test_flush();
    int o0;
    OutReady = 1'b0;
    send(32'hFFF10093, addi_exp(32'h400));
    send(vins[12], vexp[12]);
    Flush = 1'b1; InValid = 1'b1; Instruction = 32'h0; InPC = 32'h408;
    step();
    Flush = 1'b0; InValid = 1'b0;
    sbq.delete();
    vectors++;
    if ({OutValid, InReady} !== 2'b01) begin
      miscompares++; $display("FAIL flush_state got v/r=%b required=01", {OutValid, InReady});
    end
    vectors++;
    if (InvalidCount !== 8'(inv_exp)) begin
      miscompares++; $display("FAIL flush_count got=%0d required=%0d", InvalidCount, inv_exp);
    end
    o0 = n_out;
    OutReady = 1'b1;
    step(); step(); step();
    vectors++;
    if (n_out !== o0) begin
      miscompares++; $display("FAIL flush_leak got=%0d required=%0d", n_out, o0);
    end
  endtask

  task automatic test_random_stall();
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          OutReady = 1'($urandom_range(0, 1));
          step();
        end
        OutReady = 1'b1;
      end
      begin
        foreach (vins[j]) send(vins[j], vexp[j]);
      end
    join
    OutReady = 1'b1;
    wait_drain();
  endtask

  task automatic test_reset_midstall();
    int o0;
    OutReady = 1'b0;
    send(vins[2], vexp[2]);
    send(vins[3], vexp[3]);
    Reset_n = 1'b0;
    step();
    Reset_n = 1'b1;
    sbq.delete();
    inv_exp = 0;
    vectors++;
    if ({OutValid, InReady, InvalidCount} !== {1'b0, 1'b1, 8'd0}) begin
      miscompares++; $display("FAIL reset_midstall got v=%b r=%b cnt=%0d required v=0 r=1 cnt=0", OutValid, InReady, InvalidCount);
    end
    o0 = n_out;
    OutReady = 1'b1;
    step(); step();
    vectors++;
    if (n_out !== o0) begin
      miscompares++; $display("FAIL reset_leak got=%0d required=%0d", n_out, o0);
    end
  endtask

  task automatic test_saturate();
    logic [1:0] exp_c;
    Reset_n = 1'b0; step(); Reset_n = 1'b1;
    exp_c = 2'd0;
    for (int i = 0; i < 5; i++) begin
      InValid_b = 1'b1; Instruction_b = 32'h0;
      step();
      if (exp_c != 2'd3) exp_c = exp_c + 2'd1;
      vectors++;
      if (InvalidCount_b !== exp_c) begin
        miscompares++; $display("FAIL saturate idx=%0d got=%0d required=%0d", i, InvalidCount_b, exp_c);
      end
    end
    InValid_b = 1'b0;
    Reset_n = 1'b0; step(); Reset_n = 1'b1;
    vectors++;
    if (InvalidCount_b !== 2'd0) begin
      miscompares++; $display("FAIL saturate_reset got=%0d required=0", InvalidCount_b);
    end
  endtask

  initial begin
    build_vectors();
    test_reset();
    test_latency();
    test_decode_mix();
    test_invalid();
    test_muldiv_enabled();
    test_back_to_back();
    test_stall_order();
    test_flush();
    test_random_stall();
    test_reset_midstall();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
